tx_path_top: RTL and testbench

Transmit-path front end of the SDR. It accepts one QPSK symbol per handshake as two hard bits (I, Q) and maps each bit to a signed 12-bit baseband level of ±1/√2 full scale. It buffers the results in a small FIFO and emits packed {I, Q} samples on an AXI-Stream-style output toward the DAC/upsampling chain.

---
 rtl/tx_path_top.sv | 120 ++++++++++++
 tb/tb_tx_path_top.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tx_path_top.sv
// QPSK transmit front end: maps (I,Q) hard bits to +/-AMP levels and buffers them in a small output FIFO.
// Define TX_PATH_BYTE_IN_EN to accept a byte per handshake and serialize it as four symbols, MSB pair first.
module tx_path_top #(
  parameter int OUT_W      = 12,
  parameter int AMP        = 1447,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_I,
  input  logic               in_Q,
  input  logic [7:0]         in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*OUT_W-1:0] out_data
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]    L_FULL = CW'(FIFO_DEPTH);
  localparam logic [OUT_W-1:0] L_POS  = OUT_W'(AMP);
  localparam logic [OUT_W-1:0] L_NEG  = OUT_W'(-AMP);

  logic [2*OUT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]      r_wr, r_rd;
  logic [CW-1:0]      r_count;
  logic               r_in_ready;
  logic [2*OUT_W-1:0] r_out_data;

  logic               w_push, w_pop;
  logic [1:0]         w_sym;
  logic [2*OUT_W-1:0] w_push_data, w_head_nxt;
  logic [PW-1:0]      w_rd_nxt;
  logic [CW-1:0]      w_count_nxt;
  logic               w_in_ready_nxt;

  assign out_valid = (r_count != '0);
  assign out_data  = r_out_data;
  assign in_ready  = r_in_ready;
  assign w_pop     = out_valid && out_ready;

  assign w_push_data = {(w_sym[1] ? L_NEG : L_POS), (w_sym[0] ? L_NEG : L_POS)};
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  assign w_rd_nxt    = r_rd + PW'(w_pop);

`ifdef TX_PATH_BYTE_IN_EN
  logic [7:0] r_shift;
  logic [2:0] r_left;
  logic       w_accept;
  logic [2:0] w_left_nxt;
  logic       w_unused_bits;

  assign w_unused_bits = in_I ^ in_Q;
  assign w_accept      = in_valid && r_in_ready;
  // A full FIFO can still take a symbol when a pop happens on the same edge.
  assign w_push        = (r_left != 3'd0) && ((r_count != L_FULL) || w_pop);
  assign w_sym         = r_shift[7:6];

  always_comb begin
    w_left_nxt = r_left;
    if (w_accept)
      w_left_nxt = 3'd4;
    else if (w_push)
      w_left_nxt = r_left - 3'd1;
  end

  assign w_in_ready_nxt = (w_left_nxt == 3'd0) && (w_count_nxt != L_FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
      r_left  <= '0;
    end else begin
      r_left <= w_left_nxt;
      if (w_accept)
        r_shift <= in_data;
      else if (w_push)
        r_shift <= {r_shift[5:0], 2'b00};
    end
  end
`else
  logic w_unused_data;

  assign w_unused_data  = ^in_data;
  assign w_push         = in_valid && r_in_ready;
  assign w_sym          = {in_I, in_Q};
  assign w_in_ready_nxt = (w_count_nxt != L_FULL);
`endif

  // The pushed word is not in r_mem until after this edge, so bypass it when it becomes the new head.
  always_comb begin
    w_head_nxt = r_out_data;
    if (w_count_nxt != '0)
      w_head_nxt = (w_push && (w_rd_nxt == r_wr)) ? w_push_data : r_mem[w_rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr] <= w_push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_wr       <= r_wr + PW'(w_push);
      r_rd       <= w_rd_nxt;
      r_count    <= w_count_nxt;
      r_in_ready <= w_in_ready_nxt;
      r_out_data <= w_head_nxt;
    end
  end

endmodule

// File: tb/tb_tx_path_top.sv
// Bench for tx_path_top (default build): fixed vector table, random streaming against a queue model, async reset cases.
module tb_tx_path_top;

  localparam int DEPTH = 4;
  localparam logic [11:0] P = 12'h5A7;
  localparam logic [11:0] N = 12'hA59;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_I = 1'b0;
  logic        in_Q = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_data;

  int errors = 0;
  int checks = 0;
  int xfers  = 0;

  logic [23:0] mq[$];
  logic        m_ready = 1'b0;
  logic [23:0] m_data = 24'h0;

  typedef struct {
    logic        iv;
    logic        i;
    logic        q;
    logic        o;
    logic        ev;
    logic [23:0] ed;
    logic        er;
  } vec_t;

  vec_t tbl[16];

  always #5 clk = ~clk;

  tx_path_top dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_I      (in_I),
    .in_Q      (in_Q),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  function automatic logic [23:0] map_sym(input logic i, input logic q);
    return {(i ? -12'sd1447 : 12'sd1447), (q ? -12'sd1447 : 12'sd1447)};
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ready = 1'b0;
    m_data  = 24'h0;
  endtask

  task automatic model_step();
    logic pop;
    logic push;
    pop  = (mq.size() > 0) && out_ready;
    push = in_valid && m_ready;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(map_sym(in_I, in_Q));
    m_ready = (mq.size() < DEPTH);
    if (mq.size() > 0) m_data = mq[0];
  endtask

  task automatic model_check();
    check("model_valid", {23'b0, out_valid}, {23'b0, (mq.size() > 0)});
    check("model_data", out_data, m_data);
    check("model_ready", {23'b0, in_ready}, {23'b0, m_ready});
  endtask

  // Called at a falling edge; returns at the next falling edge after model check.
  task automatic cycle(input logic iv, input logic i, input logic q, input logic o);
    in_valid  = iv;
    in_I      = i;
    in_Q      = q;
    out_ready = o;
    if (out_valid && out_ready) xfers++;
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
  endtask

  initial begin
    // mapping, one per cycle with out_ready high
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, {P, P}, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, {P, N}, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, {N, P}, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, {N, N}, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, {N, N}, 1'b1};
    // backpressure fill, ignored push at full
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, {P, N}, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, {P, N}, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, {P, N}, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, {P, N}, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, {P, N}, 1'b0};
    // one-cycle pop at full, then refill and drain
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, {N, P}, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, {N, P}, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, {N, N}, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, {P, P}, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, {N, N}, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, {N, N}, 1'b1};

    // reset held for two cycles
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", {23'b0, out_valid}, 24'h0);
    check("rst_data", out_data, 24'h0);
    check("rst_ready", {23'b0, in_ready}, 24'h0);
    rst = 1'b1;
    model_reset();
    #1;
    check("rel_ready_pre", {23'b0, in_ready}, 24'h0);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("rel_ready_post", {23'b0, in_ready}, 24'h1);
    model_check();

    for (int k = 0; k < 16; k++) begin
      cycle(tbl[k].iv, tbl[k].i, tbl[k].q, tbl[k].o);
      check($sformatf("vec%0d_valid", k), {23'b0, out_valid}, {23'b0, tbl[k].ev});
      check($sformatf("vec%0d_data", k), out_data, tbl[k].ed);
      check($sformatf("vec%0d_ready", k), {23'b0, in_ready}, {23'b0, tbl[k].er});
    end

    // 100 back-to-back random symbols, then one drain cycle
    xfers = 0;
    for (int k = 0; k < 100; k++)
      cycle(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("stream_xfers", 24'(xfers), 24'd100);

    // random handshakes on both sides
    for (int k = 0; k < 300; k++)
      cycle(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
            ($urandom_range(3) != 0));

    // drain, queue three, then async reset between edges
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check("pre_rst_valid", {23'b0, out_valid}, 24'h1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", {23'b0, out_valid}, 24'h0);
    check("mid_rst_ready", {23'b0, in_ready}, 24'h0);
    check("mid_rst_data", out_data, 24'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("post_rst_empty", {23'b0, out_valid}, 24'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check("post_rst_valid", {23'b0, out_valid}, 24'h1);
    check("post_rst_data", out_data, {N, P});
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("post_rst_drained", {23'b0, out_valid}, 24'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
